// File: rtl/mtrx_rect_fill.sv
// Rectangle fill engine for the 32x32 matrix frame-buffer write port.
// Optional abort input is built when MTRX_FILL_ABORT_EN is defined.
module mtrx_rect_fill #(
    parameter int AW = 11,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          buf_sel,
    input  logic [4:0]    x0,
    input  logic [4:0]    y0,
    input  logic [4:0]    x1,
    input  logic [4:0]    y1,
    input  logic [DW-1:0] color,
    input  logic          host_wr,
    input  logic [AW-1:0] host_wr_addr,
    input  logic [DW-1:0] host_wr_data,
`ifdef MTRX_FILL_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic          wr,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t        state_q;
    logic [4:0]    x_q;
    logic [4:0]    y_q;
    logic [4:0]    xmin_q;
    logic [4:0]    xmax_q;
    logic [4:0]    ymax_q;
    logic          buf_q;
    logic [DW-1:0] col_q;
    logic          busy_q;
    logic          done_q;
    logic          wr_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;

    logic [4:0]    xmin_d;
    logic [4:0]    xmax_d;
    logic [4:0]    ymin_d;
    logic [4:0]    ymax_d;
    logic          abort_d;

    assign xmin_d = (x0 < x1) ? x0 : x1;
    assign xmax_d = (x0 < x1) ? x1 : x0;
    assign ymin_d = (y0 < y1) ? y0 : y1;
    assign ymax_d = (y0 < y1) ? y1 : y0;

`ifdef MTRX_FILL_ABORT_EN
    assign abort_d = abort;
`else
    assign abort_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymax_q    <= '0;
            buf_q     <= 1'b0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= host_wr;
            // Host writes own the port in every state; the engine yields.
            if (host_wr) begin
                wr_addr_q <= host_wr_addr;
                wr_data_q <= host_wr_data;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        buf_q   <= buf_sel;
                        col_q   <= color;
                        xmin_q  <= xmin_d;
                        xmax_q  <= xmax_d;
                        ymax_q  <= ymax_d;
                        x_q     <= xmin_d;
                        y_q     <= ymin_d;
                        busy_q  <= 1'b1;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (abort_d) begin
                        state_q <= DONE;
                    end else if (!host_wr) begin
                        wr_q      <= 1'b1;
                        wr_addr_q <= AW'({buf_q, y_q, x_q});
                        wr_data_q <= col_q;
                        if (x_q == xmax_q) begin
                            x_q <= xmin_q;
                            if (y_q == ymax_q) begin
                                state_q <= DONE;
                            end else begin
                                y_q <= y_q + 5'd1;
                            end
                        end else begin
                            x_q <= x_q + 5'd1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr      = wr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
